sprite_move_ctrl: RTL and testbench

Parametrised successor to the single-sprite movement controller. Converts four raw direction buttons into a bounded sprite position for the VGA renderer. Adds per-button debounce, hold-to-repeat motion, diagonal moves, a clamp/wrap edge mode, edge flags and a move strobe. It sits between the board switches and the VGA display block; one instance is used per controllable sprite.

---
 rtl/sprite_move_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_sprite_move_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sprite_move_ctrl                                         |
// | Purpose : debounced four-button sprite mover with hold-to-repeat,  |
// |           diagonal steps, clamp/wrap edges, edge flags and strobe. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sprite_move_ctrl #(
  parameter int COORD_W         = 10,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int STEP            = 4,
  parameter int INIT_X          = 304,
  parameter int INIT_Y          = 224,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 1250000,
  parameter int WRAP            = 0
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Enable,
  input  logic               i_Recenter,
  input  logic               i_Up,
  input  logic               i_Dn,
  input  logic               i_Lt,
  input  logic               i_Rt,
  output logic [COORD_W-1:0] o_Sprite_X,
  output logic [COORD_W-1:0] o_Sprite_Y,
  output logic               o_Moved,
  output logic [3:0]         o_Edge
);

  localparam int AW        = COORD_W + 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int C_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W     = $clog2(C_RPT_MAX + 1);

  localparam logic [AW-1:0]      C_MAX_X  = AW'(H_ACTIVE - SPRITE_W);
  localparam logic [AW-1:0]      C_MAX_Y  = AW'(V_ACTIVE - SPRITE_H);
  localparam logic [AW-1:0]      C_STEP   = AW'(STEP);
  localparam logic [COORD_W-1:0] C_INIT_X = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] C_INIT_Y = COORD_W'(INIT_Y);
  localparam logic [CNT_W-1:0]   C_DELAY  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   C_PERIOD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [DB_W-1:0]    C_DB_END = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] C_EDGE_INIT = {C_INIT_X == '0, {1'b0, C_INIT_X} == C_MAX_X,
                                        C_INIT_Y == '0, {1'b0, C_INIT_Y} == C_MAX_Y};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Button bit order everywhere below: [3]=up [2]=down [1]=left [0]=right.
  logic [3:0] raw;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0] btn_db;

  assign raw = {i_Up, i_Dn, i_Lt, i_Rt};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_lvl_q, db_lvl_d;

    always_comb begin
      db_cnt_d = '0;
      db_lvl_d = db_lvl_q;
      if (sync2_q[b] != db_lvl_q) begin
        if (db_cnt_q == C_DB_END) begin
          db_lvl_d = sync2_q[b];
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        db_cnt_q <= '0;
        db_lvl_q <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        db_lvl_q <= db_lvl_d;
      end
    end

    assign btn_db[b] = db_lvl_q;
  end

  // Opposing buttons cancel, so each axis carries at most one active direction.
  logic [3:0] vec;
  logic       vec_nz;

  assign vec    = {btn_db[3] & ~btn_db[2], btn_db[2] & ~btn_db[3],
                   btn_db[1] & ~btn_db[0], btn_db[0] & ~btn_db[1]};
  assign vec_nz = |vec;

  function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] p,
                                                   input logic inc,
                                                   input logic dec,
                                                   input logic [AW-1:0] max_p);
    logic [AW-1:0] pw;
    logic [AW-1:0] res;
    pw  = {1'b0, p};
    res = pw;
    if (inc) begin
      if (pw + C_STEP > max_p) res = (WRAP != 0) ? '0 : max_p;
      else                     res = pw + C_STEP;
    end else if (dec) begin
      if (pw < C_STEP) res = (WRAP != 0) ? max_p : '0;
      else             res = pw - C_STEP;
    end
    step_axis = COORD_W'(res);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [3:0]       vec_q, vec_d;
  logic             do_step;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_Recenter || !i_Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vec_nz) state_d = ST_HOLD;
        end
        ST_HOLD, ST_REPEAT: begin
          if (!vec_nz)                state_d = ST_IDLE;
          else if (vec != vec_q)      state_d = ST_HOLD;
          else if (rpt_cnt_q == '0)   state_d = ST_REPEAT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A changed but still nonzero vector restarts the press: immediate step, full delay.
  always_comb begin
    do_step   = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    vec_d     = vec_q;
    if (i_Recenter || !i_Enable) begin
      rpt_cnt_d = '0;
      vec_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vec_nz) begin
            do_step   = 1'b1;
            rpt_cnt_d = C_DELAY;
            vec_d     = vec;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!vec_nz) begin
            rpt_cnt_d = '0;
            vec_d     = '0;
          end else if (vec != vec_q) begin
            do_step   = 1'b1;
            rpt_cnt_d = C_DELAY;
            vec_d     = vec;
          end else if (rpt_cnt_q == '0) begin
            do_step   = 1'b1;
            rpt_cnt_d = C_PERIOD;
          end else begin
            rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          rpt_cnt_d = '0;
          vec_d     = '0;
        end
      endcase
    end
  end

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               moved_q, moved_d;
  logic [3:0]         edge_q, edge_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_Recenter) begin
      x_d = C_INIT_X;
      y_d = C_INIT_Y;
    end else if (do_step) begin
      x_d = step_axis(x_q, vec[0], vec[1], C_MAX_X);
      y_d = step_axis(y_q, vec[2], vec[3], C_MAX_Y);
    end
    moved_d = (x_d != x_q) || (y_d != y_q);
    edge_d  = {x_d == '0, {1'b0, x_d} == C_MAX_X, y_d == '0, {1'b0, y_d} == C_MAX_Y};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      x_q     <= C_INIT_X;
      y_q     <= C_INIT_Y;
      moved_q <= 1'b0;
      edge_q  <= C_EDGE_INIT;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
      edge_q  <= edge_d;
    end
  end

  assign o_Sprite_X = x_q;
  assign o_Sprite_Y = y_q;
  assign o_Moved    = moved_q;
  assign o_Edge     = edge_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_move_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_sprite_move_ctrl                                      |
// | Purpose : three sprite_move_ctrl instances (centre clamp, right-   |
// |           edge clamp, top-edge wrap) against a behavioural model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sprite_move_ctrl;

  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int ST   = 4;
  localparam int MAXX = 640 - 32;
  localparam int MAXY = 480 - 32;

  logic clk = 1'b0;
  logic rst_n, en, rc, up, dn, lt, rt;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       m0, m1, m2;
  logic [3:0] e0, e1, e2;
  wire [74:0] dut_vec = {x0, y0, m0, e0, x1, y1, m1, e1, x2, y2, m2, e2};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_move_ctrl #(.STEP(ST), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                     .INIT_X(304), .INIT_Y(224), .WRAP(0)) u_def (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Recenter(rc),
    .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
    .o_Sprite_X(x0), .o_Sprite_Y(y0), .o_Moved(m0), .o_Edge(e0));

  sprite_move_ctrl #(.STEP(ST), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                     .INIT_X(606), .INIT_Y(224), .WRAP(0)) u_clamp (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Recenter(rc),
    .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
    .o_Sprite_X(x1), .o_Sprite_Y(y1), .o_Moved(m1), .o_Edge(e1));

  sprite_move_ctrl #(.STEP(ST), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                     .INIT_X(304), .INIT_Y(2), .WRAP(1)) u_wrap (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Recenter(rc),
    .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
    .o_Sprite_X(x2), .o_Sprite_Y(y2), .o_Moved(m2), .o_Edge(e2));

  // Behavioural model: a press has an age; steps fall at age 0 and at RD + n*RP.
  int   ix[3] = '{304, 606, 304};
  int   iy[3] = '{224, 224, 2};
  bit   wr[3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] s1, s2, db;  // [0]=up [1]=dn [2]=lt [3]=rt
  int   run[4];
  bit   act;
  int   ldx, ldy, age;
  int   px[3], py[3];
  bit   mv[3];

  function automatic int mstep(int p, int d, int mx, bit w);
    if (d > 0) return (p + ST > mx) ? (w ? 0 : mx) : p + ST;
    if (d < 0) return (p < ST) ? (w ? mx : 0) : p - ST;
    return p;
  endfunction

  function automatic void model_reset();
    s1 = '0; s2 = '0; db = '0;
    for (int b = 0; b < 4; b++) run[b] = 0;
    act = 1'b0; ldx = 0; ldy = 0; age = 0;
    for (int k = 0; k < 3; k++) begin
      px[k] = ix[k]; py[k] = iy[k]; mv[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int dx, dy, ox, oy;
    bit stp;
    logic [3:0] raw;
    raw = {rt, lt, dn, up};
    dx  = int'(db[3]) - int'(db[2]);
    dy  = int'(db[1]) - int'(db[0]);
    stp = 1'b0;
    if (rc || !en || (dx == 0 && dy == 0)) begin
      act = 1'b0;
    end else if (!act || dx != ldx || dy != ldy) begin
      act = 1'b1; ldx = dx; ldy = dy; age = 0; stp = 1'b1;
    end else begin
      age++;
      if (age >= RD && (age - RD) % RP == 0) stp = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      ox = px[k]; oy = py[k];
      if (rc) begin
        px[k] = ix[k]; py[k] = iy[k];
      end else if (stp) begin
        px[k] = mstep(px[k], dx, MAXX, wr[k]);
        py[k] = mstep(py[k], dy, MAXY, wr[k]);
      end
      mv[k] = (px[k] != ox) || (py[k] != oy);
    end
    for (int b = 0; b < 4; b++) begin
      if (s2[b] !== db[b]) begin
        run[b]++;
        if (run[b] == DB) begin db[b] = s2[b]; run[b] = 0; end
      end else begin
        run[b] = 0;
      end
    end
    s2 = s1;
    s1 = raw;
  endfunction

  function automatic logic [74:0] model_vec();
    logic [74:0] v;
    logic [24:0] s;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      s = {10'(px[k]), 10'(py[k]), mv[k], px[k] == 0, px[k] == MAXX, py[k] == 0, py[k] == MAXY};
      v = {v[49:0], s};
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; rc = 1'b0;
    {up, dn, lt, rt} = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_model: dut=%h model=%h", dut_vec, model_vec()); end
    checks++;
    if ({x0, y0} !== {10'd304, 10'd224}) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 304,224", x0, y0); end
    checks++;
    if ({m0, m1, m2} !== 3'b000) begin errors++; $display("FAIL reset_moved: got %b expected 000", {m0, m1, m2}); end
    checks++;
    if ({e0, e1, e2} !== 12'h000) begin errors++; $display("FAIL reset_edge: got %h expected 000", {e0, e1, e2}); end
    checks++;
    if ({x1, y2} !== {10'd606, 10'd2}) begin errors++; $display("FAIL reset_init_param: got %0d,%0d expected 606,2", x1, y2); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL idle_model: dut=%h model=%h", dut_vec, model_vec()); end
    end
  endtask

  task automatic test_debounce();
    int first, pulses;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      rt = ((i / 2) % 2 == 1);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL debounce_model: dut=%h model=%h", dut_vec, model_vec()); end
      checks++;
      if (m0 !== 1'b0) begin errors++; $display("FAIL debounce_toggle_moved: got %b expected 0", m0); end
    end
    rt = 1'b1; first = 0; pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL debounce_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) begin pulses++; if (first == 0) first = i; end
    end
    checks++;
    if (first != 7) begin errors++; $display("FAIL debounce_latency: got %0d expected 7", first); end
    checks++;
    if (x0 !== 10'd308) begin errors++; $display("FAIL debounce_x: got %0d expected 308", x0); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL debounce_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_repeat();
    int got[$];
    int exp_off[$];
    int found, late;
    exp_off = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
    do_reset();
    dn = 1'b1; found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL repeat_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL repeat_first_step: got none expected step within 12 cycles"); return; end
    got.push_back(0);
    for (int off = 1; off < 60; off++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL repeat_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) got.push_back(off);
    end
    checks++;
    if (got.size() != exp_off.size()) begin
      errors++; $display("FAIL repeat_count: got %0d expected %0d", got.size(), exp_off.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] != exp_off[i]) begin errors++; $display("FAIL repeat_offset[%0d]: got %0d expected %0d", i, got[i], exp_off[i]); end
      end
    end
    checks++;
    if (y0 !== 10'(224 + ST * exp_off.size())) begin errors++; $display("FAIL repeat_y: got %0d expected %0d", y0, 224 + ST * exp_off.size()); end
    dn = 1'b0; late = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL release_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (i >= 10 && m0 === 1'b1) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL release_steps: got %0d expected 0", late); end
  endtask

  task automatic test_clamp();
    int found, cl, df;
    do_reset();
    rt = 1'b1; found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL clamp_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m1 === 1'b1) found = 1;
    end
    checks++;
    if (x1 !== 10'd608 || e1[2] !== 1'b1) begin errors++; $display("FAIL clamp_first: got x=%0d right=%b expected x=608 right=1", x1, e1[2]); end
    cl = 0; df = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL clamp_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m1 === 1'b1) cl++;
      if (m0 === 1'b1) df++;
    end
    checks++;
    if (cl != 0) begin errors++; $display("FAIL clamp_moved: got %0d expected 0", cl); end
    checks++;
    if (df != 5) begin errors++; $display("FAIL clamp_peer_repeats: got %0d expected 5", df); end
    checks++;
    if (x1 !== 10'd608 || e1 !== 4'b0100) begin errors++; $display("FAIL clamp_hold: got x=%0d edge=%b expected 608 0100", x1, e1); end
  endtask

  task automatic test_wrap();
    int found;
    do_reset();
    up = 1'b1;
    for (int n = 0; n < 2; n++) begin
      found = 0;
      for (int i = 0; i < 25 && found == 0; i++) begin
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin errors++; $display("FAIL wrap_model: dut=%h model=%h", dut_vec, model_vec()); end
        if (m2 === 1'b1) found = 1;
      end
      checks++;
      if (n == 0 && (y2 !== 10'd448 || e2[0] !== 1'b1)) begin
        errors++; $display("FAIL wrap_first: got y=%0d bottom=%b expected 448 1", y2, e2[0]);
      end else if (n == 1 && (y2 !== 10'd444 || e2[0] !== 1'b0)) begin
        errors++; $display("FAIL wrap_second: got y=%0d bottom=%b expected 444 0", y2, e2[0]);
      end
    end
  endtask

  task automatic test_diagonal();
    int found, gap;
    do_reset();
    up = 1'b1; rt = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL diag_model: dut=%h model=%h", dut_vec, model_vec()); end
    end
    checks++;
    if ({x0, y0} !== {10'd308, 10'd220}) begin errors++; $display("FAIL diag_step: got %0d,%0d expected 308,220", x0, y0); end
    up = 1'b0; found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL diag_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) found = 1;
    end
    checks++;
    if (found == 0 || {x0, y0} !== {10'd312, 10'd220}) begin errors++; $display("FAIL diag_release_step: got %0d,%0d expected 312,220", x0, y0); end
    gap = 0; found = 0;
    for (int i = 1; i <= 25 && found == 0; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL diag_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) begin found = 1; gap = i; end
    end
    checks++;
    if (gap != RD) begin errors++; $display("FAIL diag_delay_restart: got %0d expected %0d", gap, RD); end
    do_reset();
    lt = 1'b1; rt = 1'b1; dn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL oppose_model: dut=%h model=%h", dut_vec, model_vec()); end
    end
    checks++;
    if ({x0, y0} !== {10'd304, 10'd228}) begin errors++; $display("FAIL oppose_step: got %0d,%0d expected 304,228", x0, y0); end
  endtask

  task automatic test_enable();
    int pulses;
    do_reset();
    en = 1'b0; rt = 1'b1; pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL enable_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || x0 !== 10'd304) begin errors++; $display("FAIL enable_low: got x=%0d pulses=%0d expected 304 0", x0, pulses); end
    en = 1'b1;
    tick();
    checks++;
    if (m0 !== 1'b1 || x0 !== 10'd308) begin errors++; $display("FAIL enable_high: got x=%0d moved=%b expected 308 1", x0, m0); end
  endtask

  task automatic test_recenter();
    do_reset();
    lt = 1'b1; up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL recenter_model: dut=%h model=%h", dut_vec, model_vec()); end
    end
    rc = 1'b1;
    tick();
    rc = 1'b0;
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL recenter_model: dut=%h model=%h", dut_vec, model_vec()); end
    checks++;
    if ({x0, y0, m0} !== {10'd304, 10'd224, 1'b1}) begin errors++; $display("FAIL recenter_load: got %0d,%0d m=%b expected 304,224 m=1", x0, y0, m0); end
    tick();
    checks++;
    if ({x0, y0, m0} !== {10'd300, 10'd220, 1'b1}) begin errors++; $display("FAIL recenter_restep: got %0d,%0d m=%b expected 300,220 m=1", x0, y0, m0); end
  endtask

  task automatic test_reset_midhold();
    int first;
    do_reset();
    rt = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({x0, y0, m0, e0} !== {10'd304, 10'd224, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL midhold_reset: got %0d,%0d m=%b expected 304,224 m=0", x0, y0, m0);
    end
    checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL midhold_model: dut=%h model=%h", dut_vec, model_vec()); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL midhold_model: dut=%h model=%h", dut_vec, model_vec()); end
      if (m0 === 1'b1 && first == 0) first = i;
    end
    checks++;
    if (first != 7) begin errors++; $display("FAIL midhold_rearm: got %0d expected 7", first); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; rc = 1'b0;
    {up, dn, lt, rt} = 4'b0000;
    test_reset();
    test_debounce();
    test_repeat();
    test_clamp();
    test_wrap();
    test_diagonal();
    test_enable();
    test_recenter();
    test_reset_midhold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
